// File: rtl/io_write_ctrl.sv
// rtl/io_write_ctrl.sv - LED/7-seg output register block with scanned hex display (option: SEG_ZERO_BLANK_EN)
module io_write_ctrl #(
    parameter int SCAN_DIV   = 100000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iow,
    input  logic        ledctrl,
    input  logic        segctrl,
    input  logic        addr_half,
    input  logic [15:0] iowrite_data,
    output logic [15:0] led,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cathode
);

    localparam int              CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   DIV_MAX = CW'(SCAN_DIV - 1);
    localparam logic [2:0]      DIG_MAX = 3'(NUM_DIGITS - 1);

    logic [31:0]   seg_val;
    logic [CW-1:0] div_cnt;
    logic [2:0]    digit_idx;
    logic [3:0]    nibble;
    logic          blank;
    logic [7:0]    cathode_next;

    // Segment pattern {g,f,e,d,c,b,a}, active-low
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nibble = seg_val[{digit_idx, 2'b00} +: 4];
`ifdef SEG_ZERO_BLANK_EN
        // Blank a digit when it and everything above it are zero; digit 0 always shows
        blank = (digit_idx != 3'd0) && ((seg_val >> {digit_idx, 2'b00}) == 32'h0);
`else
        blank = 1'b0;
`endif
        cathode_next = blank ? 8'hFF : {1'b1, hex7(nibble)};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led         <= 16'h0;
            seg_val     <= 32'h0;
            div_cnt     <= '0;
            digit_idx   <= 3'd0;
            seg_an      <= 8'hFF;
            seg_cathode <= 8'hFF;
        end else begin
            if (iow && ledctrl)
                led <= iowrite_data;
            if (iow && segctrl) begin
                if (addr_half)
                    seg_val[31:16] <= iowrite_data;
                else
                    seg_val[15:0] <= iowrite_data;
            end
            // Scan runs freely; CPU writes never disturb it
            if (div_cnt == DIV_MAX) begin
                div_cnt   <= '0;
                digit_idx <= (digit_idx == DIG_MAX) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            seg_an      <= ~(8'b1 << digit_idx);
            seg_cathode <= cathode_next;
        end
    end

endmodule

// File: tb/tb_io_write_ctrl.sv
// tb/tb_io_write_ctrl.sv - self-checking bench for io_write_ctrl (directed + random vs arithmetic model)
module tb_io_write_ctrl;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset, iow, ledctrl, segctrl, addr_half;
    logic [15:0] iowrite_data;
    logic [15:0] led;
    logic [7:0]  seg_an, seg_cathode;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: register contents plus edge count since the last reset
    logic [15:0] led_m;
    logic [31:0] seg_m;
    int          k_m;
    logic [7:0]  exp_an, exp_cath;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] an_tab   [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    logic [7:0] cath_tab [8]  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    io_write_ctrl #(.SCAN_DIV(SD), .NUM_DIGITS(8)) dut (
        .clk(clk), .reset(reset), .iow(iow), .ledctrl(ledctrl), .segctrl(segctrl),
        .addr_half(addr_half), .iowrite_data(iowrite_data),
        .led(led), .seg_an(seg_an), .seg_cathode(seg_cathode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int          d;
        logic [31:0] shown;
        bit          blank;
        if (!reset) begin
            led_m = 16'h0; seg_m = 32'h0; k_m = 0;
            exp_an = 8'hFF; exp_cath = 8'hFF;
        end else begin
            shown  = seg_m;
            d      = (k_m / SD) % 8;
            k_m++;
            exp_an = ~(8'h01 << d);
            blank  = 1'b0;
`ifdef SEG_ZERO_BLANK_EN
            blank  = (d != 0) && ((shown >> (4 * d)) == 32'h0);
`endif
            exp_cath = blank ? 8'hFF : hex_tab[(shown >> (4 * d)) & 32'hF];
            if (iow && ledctrl) led_m = iowrite_data;
            if (iow && segctrl) begin
                if (addr_half) seg_m[31:16] = iowrite_data;
                else           seg_m[15:0]  = iowrite_data;
            end
        end
    endtask

    task automatic tick(input logic rst, input logic w, input logic lc, input logic sc,
                        input logic ah, input logic [15:0] d);
        reset = rst; iow = w; ledctrl = lc; segctrl = sc; addr_half = ah; iowrite_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check("led", {16'h0, led}, {16'h0, led_m});
        check("seg_an", {24'h0, seg_an}, {24'h0, exp_an});
        check("seg_cathode", {24'h0, seg_cathode}, {24'h0, exp_cath});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    endtask

    initial begin
        // 1: reset with random other inputs
        tick(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_an", {24'h0, seg_an}, 32'hFF);
        check("rst_cath", {24'h0, seg_cathode}, 32'hFF);

        // 2: LED write, then ledctrl without iow must hold
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'hA5C3);
        check("led_write", {16'h0, led}, 32'h0000A5C3);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF);
        check("led_hold", {16'h0, led}, 32'h0000A5C3);

        // 3: full scan of 76543210, then wrap
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h3210);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h7654);
        for (int k = 3; k <= 36; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            check("scan_an", {24'h0, seg_an}, {24'h0, an_tab[((k - 1) / SD) % 8]});
            check("scan_cath", {24'h0, seg_cathode}, {24'h0, cath_tab[((k - 1) / SD) % 8]});
        end

        // 4: simultaneous LED + 7-seg write
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h000F);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("dual_led", {16'h0, led}, 32'h0000000F);
        check("dual_cath", {24'h0, seg_cathode}, 32'h8E);

        // 5: reset while digit 5 is lit
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        idle(21);
        check("d5_an", {24'h0, seg_an}, 32'hDF);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("midrst_an", {24'h0, seg_an}, 32'hFF);
        check("midrst_cath", {24'h0, seg_cathode}, 32'hFF);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        check("restart_an", {24'h0, seg_an}, 32'hFE);

        // 6: 000000A0 (leading zeros)
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00A0);
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000);
        for (int k = 3; k <= 32; k++) begin
            logic [7:0] e;
            int         d;
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            d = (k - 1) / SD;
`ifdef SEG_ZERO_BLANK_EN
            e = (d == 0) ? 8'hC0 : (d == 1) ? 8'h88 : 8'hFF;
`else
            e = (d == 1) ? 8'h88 : 8'hC0;
`endif
            check("lz_cath", {24'h0, seg_cathode}, {24'h0, e});
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 59) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
